// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_port_arbiter: round-robin share of one data-memory port, with lock.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_port_arbiter #(
  parameter int N_REQ    = 3,
  parameter int LOCK_MAX = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic [N_REQ-1:0]     req_lock_i,
  input  logic [N_REQ*32-1:0]  req_addr_i,
  input  logic [N_REQ*32-1:0]  req_wdata_i,
  input  logic [N_REQ*4-1:0]   req_wmask_i,
  output logic [N_REQ-1:0]     rsp_valid_o,
  output logic [31:0]          rsp_data_o,
  output logic                 lock_timeout_o,
  output logic                 mem_cen_o,
  output logic [3:0]           mem_wmask_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic               lock_timeout_q, lock_timeout_d;

  logic               gnt_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   scan_idx;
  logic [N_REQ-1:0]   gnt_oh;
  logic               gnt_lock;

  // No issue is allowed while reset is held, so nothing reaches memory.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    if (!reset_i) begin
      if (state_q == ST_LOCKED) begin
        if (req_valid_i[owner_q]) begin
          gnt_any = 1'b1;
          gnt_idx = owner_q;
        end
      end else begin
        for (int k = 1; k <= N_REQ; k++) begin
          scan_idx = ((int'(last_q) + k) >= N_REQ) ? IDX_W'(int'(last_q) + k - N_REQ)
                                                    : IDX_W'(int'(last_q) + k);
          if (!gnt_any && req_valid_i[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
          end
        end
      end
    end
  end

  assign gnt_oh   = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  assign gnt_lock = gnt_any & req_lock_i[gnt_idx];

  assign req_ready_o = gnt_oh;
  assign mem_cen_o   = gnt_any;
  assign mem_wmask_o = gnt_any ? req_wmask_i[4*int'(gnt_idx) +: 4]  : 4'b0000;
  assign mem_addr_o  = gnt_any ? req_addr_i[32*int'(gnt_idx) +: 32] : 32'd0;
  assign mem_wdata_o = gnt_any ? req_wdata_i[32*int'(gnt_idx) +: 32] : 32'd0;

  // A response registered before reset must not leak out while reset is held.
  assign rsp_valid_o    = rsp_valid_q & {N_REQ{~reset_i}};
  assign rsp_data_o     = mem_rdata_i;
  assign lock_timeout_o = lock_timeout_q;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    idle_cnt_d     = idle_cnt_q;
    lock_timeout_d = 1'b0;
    rsp_valid_d    = gnt_oh;
    if (gnt_any) begin
      last_d = gnt_idx;
    end
    case (state_q)
      ST_IDLE: begin
        if (gnt_lock) begin
          state_d    = ST_LOCKED;
          owner_d    = gnt_idx;
          idle_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (gnt_any) begin
          if (gnt_lock) begin
            idle_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (idle_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
          state_d        = ST_IDLE;
          idle_cnt_d     = '0;
          lock_timeout_d = 1'b1;
        end else if (idle_cnt_q != CNT_W'(LOCK_MAX)) begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      owner_q        <= '0;
      last_q         <= IDX_W'(N_REQ - 1);
      idle_cnt_q     <= '0;
      rsp_valid_q    <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      idle_cnt_q     <= idle_cnt_d;
      rsp_valid_q    <= rsp_valid_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_port_arbiter: directed and randomized checks of dmem_port_arbiter. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dmem_port_arbiter;

  localparam int N_REQ    = 3;
  localparam int LOCK_MAX = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   req_valid;
  logic [2:0]   req_ready;
  logic [2:0]   req_lock;
  logic [95:0]  req_addr;
  logic [95:0]  req_wdata;
  logic [11:0]  req_wmask;
  logic [2:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic         lock_timeout;
  logic         mem_cen;
  logic [3:0]   mem_wmask;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.N_REQ(N_REQ), .LOCK_MAX(LOCK_MAX)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_lock_i     (req_lock),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_wmask_i    (req_wmask),
    .rsp_valid_o    (rsp_valid),
    .rsp_data_o     (rsp_data),
    .lock_timeout_o (lock_timeout),
    .mem_cen_o      (mem_cen),
    .mem_wmask_o    (mem_wmask),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int k);
    return 32'hC0DE0000 | 32'(k);
  endfunction

  // Registered-read memory, reloaded with its initial pattern during reset.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
    end else if (mem_cen) begin
      if (mem_wmask == 4'b0000) begin
        mem_rdata <= mem[mem_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [31:0] a, input logic [31:0] w, input logic [3:0] m);
    req_valid[i]          = v;
    req_lock[i]           = l;
    req_addr[32*i +: 32]  = a;
    req_wdata[32*i +: 32] = w;
    req_wmask[4*i +: 4]   = m;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [31:0] ref_mem [0:255];
  logic [2:0]  t1_ready [0:5];
  logic [31:0] t1_data  [0:2];
  logic [2:0]  exp_rsp;
  logic [2:0]  prev_gnt;
  logic        exp_rd_v;
  logic [31:0] exp_rd;
  int          wait_cnt [0:2];
  int          g;
  logic [7:0]  widx;
  logic [3:0]  wm;

  initial begin
    t1_ready[0] = 3'b001; t1_ready[1] = 3'b010; t1_ready[2] = 3'b100;
    t1_ready[3] = 3'b001; t1_ready[4] = 3'b010; t1_ready[5] = 3'b100;
    t1_data[0]  = 32'hC0DE0004; t1_data[1] = 32'hC0DE0008; t1_data[2] = 32'hC0DE000C;

    reset = 1'b1;
    req_valid = '0; req_lock = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    @(posedge clk); #1;
    sample();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_lock_timeout", 32'(lock_timeout), 32'd0);
    chk("reset_mem_cen", 32'(mem_cen), 32'd0);
    next_cycle();
    reset = 1'b0;

    // Round-robin reads with all three requesters continuously valid
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    set_req(2, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("rr_ready", 32'(req_ready), 32'(t1_ready[k]));
      chk("rr_mem_cen", 32'(mem_cen), 32'd1);
      chk("rr_mem_addr", mem_addr, 32'h10 * 32'((k % 3) + 1));
      if (k == 0) chk("rr_rsp_valid0", 32'(rsp_valid), 32'd0);
      else begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'(t1_ready[k-1]));
        chk("rr_rsp_data", rsp_data, t1_data[(k-1) % 3]);
      end
      next_cycle();
    end

    // Partial-byte write followed by readback
    req_valid = '0;
    set_req(1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'b0011);
    sample();
    chk("wr_ready", 32'(req_ready), 32'b010);
    chk("wr_mem_wmask", 32'(mem_wmask), 32'b0011);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_mem_addr", mem_addr, 32'h100);
    chk("wr_prev_rsp_valid", 32'(rsp_valid), 32'b100);
    chk("wr_prev_rsp_data", rsp_data, 32'hC0DE000C);
    next_cycle();
    set_req(1, 1'b1, 1'b0, 32'h100, 32'h0, 4'b0000);
    sample();
    chk("rd_ready", 32'(req_ready), 32'b010);
    chk("wr_ack", 32'(rsp_valid), 32'b010);
    next_cycle();
    req_valid = '0;
    sample();
    chk("idle_mem_cen", 32'(mem_cen), 32'd0);
    chk("idle_mem_addr", mem_addr, 32'd0);
    chk("idle_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("idle_mem_wdata", mem_wdata, 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd0);
    chk("rd_rsp_valid", 32'(rsp_valid), 32'b010);
    chk("rd_rsp_data", rsp_data, 32'hC0DEBEEF);
    next_cycle();

    // Requester 2 locks; requester 1's lock request must be ignored
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
    set_req(2, 1'b1, 1'b1, 32'h30, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req_lock[2] = 1'b0;
      sample();
      chk("lock_ready", 32'(req_ready), 32'b100);
      if (k > 0) begin
        chk("lock_rsp_valid", 32'(rsp_valid), 32'b100);
        chk("lock_rsp_data", rsp_data, 32'hC0DE000C);
      end
      next_cycle();
    end
    req_valid[2] = 1'b0;
    sample();
    chk("unlock_next_ready", 32'(req_ready), 32'b001);
    chk("unlock_rsp_valid", 32'(rsp_valid), 32'b100);
    next_cycle();
    sample();
    chk("lock1_ready", 32'(req_ready), 32'b010);
    chk("lock1_prev_rsp", 32'(rsp_valid), 32'b001);
    chk("lock1_prev_data", rsp_data, 32'hC0DE0004);
    next_cycle();

    // Requester 1 holds the lock but goes idle until forced release
    req_valid[1] = 1'b0;
    for (int k = 0; k < LOCK_MAX; k++) begin
      sample();
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_mem_cen", 32'(mem_cen), 32'd0);
      chk("hold_lock_timeout", 32'(lock_timeout), 32'd0);
      if (k == 0) chk("hold_rsp_valid", 32'(rsp_valid), 32'b010);
      next_cycle();
    end
    sample();
    chk("timeout_ready", 32'(req_ready), 32'b001);
    chk("timeout_pulse", 32'(lock_timeout), 32'd1);
    next_cycle();
    req_valid[0] = 1'b0;
    sample();
    chk("timeout_pulse_end", 32'(lock_timeout), 32'd0);
    chk("timeout_grant_rsp", 32'(rsp_valid), 32'b001);
    next_cycle();

    // Reset in the cycle after an issue
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    sample();
    chk("pre_reset_ready", 32'(req_ready), 32'b010);
    next_cycle();
    reset = 1'b1;
    req_valid = '0;
    sample();
    chk("in_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("in_reset_mem_cen", 32'(mem_cen), 32'd0);
    next_cycle();
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    set_req(2, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    sample();
    chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_reset_ready", 32'(req_ready), 32'b001);
    next_cycle();
    req_valid = '0;
    sample();
    chk("post_reset_idle_cen", 32'(mem_cen), 32'd0);
    chk("post_reset_rsp", 32'(rsp_valid), 32'b001);
    chk("post_reset_data", rsp_data, 32'hC0DE0004);
    next_cycle();

    // Randomized traffic against a reference memory
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    exp_rsp  = '0;
    exp_rd_v = 1'b0;
    exp_rd   = '0;
    prev_gnt = '0;
    for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || prev_gnt[i]) begin
          wm = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
          set_req(i, 1'($urandom_range(0, 1)), 1'b0, 32'($urandom_range(0, 15)) << 2,
                  32'($urandom), wm);
        end
      end
      sample();
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      if (exp_rd_v) chk("rnd_rsp_data", rsp_data, exp_rd);
      chk("rnd_ready_subset", 32'(req_ready & ~req_valid), 32'd0);
      chk("rnd_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      chk("rnd_mem_cen", 32'(mem_cen), 32'(|req_valid));
      exp_rsp  = req_ready;
      exp_rd_v = 1'b0;
      g = -1;
      for (int i = 0; i < 3; i++) if (req_ready[i]) g = i;
      if (g >= 0) begin
        chk("rnd_mem_addr", mem_addr, req_addr[32*g +: 32]);
        chk("rnd_mem_wmask", 32'(mem_wmask), 32'(req_wmask[4*g +: 4]));
        widx = req_addr[32*g + 2 +: 8];
        if (req_wmask[4*g +: 4] == 4'b0000) begin
          exp_rd_v = 1'b1;
          exp_rd   = ref_mem[widx];
        end else begin
          chk("rnd_mem_wdata", mem_wdata, req_wdata[32*g +: 32]);
          for (int b = 0; b < 4; b++)
            if (req_wmask[4*g + b]) ref_mem[widx][8*b +: 8] = req_wdata[32*g + 8*b +: 8];
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i] && !req_ready[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        chk("rnd_starvation", 32'(wait_cnt[i] < N_REQ), 32'd1);
      end
      prev_gnt = req_ready;
      next_cycle();
    end
    req_valid = '0;
    sample();
    chk("rnd_final_rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rd_v) chk("rnd_final_rsp_data", rsp_data, exp_rd);
    chk("rnd_final_cen", 32'(mem_cen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
